// File: rtl/result_drain.sv
// Drains len_i rows of global buffer P, starting at base_addr_i, onto a valid/ready stream.
// Reads are issued only against free output FIFO slots (credit), so backpressure never drops a row.
module result_drain #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 256,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              valid_o,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] len_i,
    output logic              enp_o,
    output logic              wep_o,
    output logic [ADDR_W-1:0] addrp_o,
    input  logic [DATA_W-1:0] datap_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o
);
    localparam int unsigned DEPTH = RD_LAT + 1;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_out_cnt;
    logic [ADDR_W-1:0] w_len_m1;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [RD_LAT-1:0] r_last_pipe;
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic              r_fifo_last [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_occ;
    logic [CNT_W-1:0]  w_inflight;
    logic [CNT_W-1:0]  w_used;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + {{(CNT_W-1){1'b0}}, r_vld_pipe[i]};
        end
    end

    assign w_len_m1  = len_i - ADDR_W'(1);
    assign w_used    = r_occ + w_inflight;
    assign m_valid_o = (r_occ != '0);
    assign m_data_o  = r_fifo_data[r_rptr];
    assign m_last_o  = r_fifo_last[r_rptr];
    assign w_pop     = m_valid_o & m_ready_i;
    assign w_push    = r_vld_pipe[RD_LAT-1];
    // The slot freed by this cycle's pop counts as credit, giving one row per cycle.
    assign w_issue   = (r_state == StBusy) && (r_rd_cnt < len_i) &&
                       (w_used < CNT_W'(DEPTH) + {{(CNT_W-1){1'b0}}, w_pop});
    assign enp_o     = w_issue;
    assign wep_o     = 1'b0;
    assign addrp_o   = w_issue ? base_addr_i + r_rd_cnt : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        valid_o      = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_next = (len_i != '0) ? StBusy : StDone;
                end
            end
            StBusy: begin
                if (w_pop && m_last_o) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                valid_o = 1'b1;
                if (!start_i) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (r_state != StBusy) begin
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + ADDR_W'(1);
            end
        end
    end

    // The last flag rides alongside the read so it stays paired with its row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_issue;
            r_last_pipe[0] <= w_issue && (r_rd_cnt == w_len_m1);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= datap_i;
                r_fifo_last[r_wptr] <= r_last_pipe[RD_LAT-1];
                r_wptr              <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_occ <= r_occ - CNT_W'(1);
            end
        end
    end

    last_matches_count: assert property (@(posedge clk_i) disable iff (rst_i)
        w_pop |-> (m_last_o == (r_out_cnt == w_len_m1)));

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: one instance per read latency, a P memory model each,
// and a monitor that checks read addresses and output beats against queued expectations.
module tb_result_drain;
    localparam int AW = 16;
    localparam int DW = 256;
    localparam logic [DW-1:0] GARB = {8{32'hDEAD_BEEF}};

    logic clk = 1'b0;
    logic rst;
    logic start, sel, ready;
    logic [AW-1:0] base, len;
    int   rmode;
    int   cyc = 0;

    logic a_valid, a_enp, a_wep, a_mvalid, a_mlast;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_datap, a_mdata;
    logic b_valid, b_enp, b_wep, b_mvalid, b_mlast, b_p1_unused;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_p1, b_datap, b_mdata;

    logic v_valid, v_enp, v_mvalid, v_mlast;
    logic [AW-1:0] v_addr;
    logic [DW-1:0] v_mdata;

    int unsigned n_chk = 0, n_pass = 0;
    logic [AW-1:0] addr_q[$];
    logic [DW:0]   exp_q[$];
    int first_enp, last_enp, enp_cnt, first_valid, first_hs, last_hs, hs_cnt;
    int outst, max_out, st_edge;
    bit stalled_prev;
    logic [DW:0] prev_beat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    result_drain #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .valid_o(a_valid),
        .base_addr_i(base), .len_i(len), .enp_o(a_enp), .wep_o(a_wep), .addrp_o(a_addr),
        .datap_i(a_datap), .m_valid_o(a_mvalid), .m_ready_i(ready), .m_data_o(a_mdata),
        .m_last_o(a_mlast)
    );

    result_drain #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start & sel), .valid_o(b_valid),
        .base_addr_i(base), .len_i(len), .enp_o(b_enp), .wep_o(b_wep), .addrp_o(b_addr),
        .datap_i(b_datap), .m_valid_o(b_mvalid), .m_ready_i(ready), .m_data_o(b_mdata),
        .m_last_o(b_mlast)
    );

    function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = {8'(l), 8'h5A, a};
        return r;
    endfunction

    // P memory models: valid data only RD_LAT cycles after a read, garbage otherwise.
    always @(posedge clk) a_datap <= a_enp ? row_of(a_addr) : GARB;
    always @(posedge clk) begin
        b_p1    <= b_enp ? row_of(b_addr) : GARB;
        b_datap <= b_p1;
    end
    assign b_p1_unused = 1'b0;

    always_comb begin
        v_valid  = sel ? b_valid  : a_valid;
        v_enp    = sel ? b_enp    : a_enp;
        v_addr   = sel ? b_addr   : a_addr;
        v_mvalid = sel ? b_mvalid : a_mvalid;
        v_mdata  = sel ? b_mdata  : a_mdata;
        v_mlast  = sel ? b_mlast  : a_mlast;
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [DW:0]   eb;
        if (rst) begin
            stalled_prev = 1'b0;
        end else begin
            if (v_enp) begin
                enp_cnt++;
                if (first_enp < 0) first_enp = cyc;
                last_enp = cyc;
                if (addr_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL addr_extra: read of %0h with none expected", v_addr);
                end else begin
                    ea = addr_q.pop_front();
                    check("addr", 512'(v_addr), 512'(ea));
                end
            end
            if (v_mvalid && first_valid < 0) first_valid = cyc;
            if (stalled_prev) begin
                check("hold_valid", 512'(v_mvalid), 512'(1));
                check("hold_beat", 512'({v_mlast, v_mdata}), 512'(prev_beat));
            end
            if (v_mvalid && ready) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL beat_extra: beat %0h with none expected", v_mdata);
                end else begin
                    eb = exp_q.pop_front();
                    check("beat_data", 512'(v_mdata), 512'(eb[DW-1:0]));
                    check("beat_last", 512'(v_mlast), 512'(eb[DW]));
                end
            end
            outst = outst + int'(v_enp) - int'(v_mvalid && ready);
            if (outst > max_out) max_out = outst;
            stalled_prev = v_mvalid && !ready;
            prev_beat    = {v_mlast, v_mdata};
        end
    end

    // Ready pattern: mode 0 always ready, mode 1 ready one cycle in three.
    initial begin
        ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready = (rmode == 0) || (cyc % 3 == 0);
        end
    end

    task automatic start_only(input bit use_b, input logic [AW-1:0] b, input logic [AW-1:0] l,
                              input int m);
        @(posedge clk);
        #1;
        sel = use_b;
        rmode = m;
        first_enp = -1; last_enp = -1; enp_cnt = 0; first_valid = -1;
        first_hs = -1; last_hs = -1; hs_cnt = 0; outst = 0; max_out = 0;
        for (int i = 0; i < int'(l); i++) begin
            addr_q.push_back(AW'(b + AW'(i)));
            exp_q.push_back({(i == int'(l) - 1), row_of(AW'(b + AW'(i)))});
        end
        base = b;
        len = l;
        start = 1'b1;
        st_edge = cyc + 1;
    endtask

    task automatic run(input bit use_b, input logic [AW-1:0] b, input logic [AW-1:0] l,
                       input int m, input int lat);
        bit ok = 1'b0;
        int done_cyc = -1;
        start_only(use_b, b, l, m);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            #1;
            if (v_valid) begin
                ok = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL done_timeout: valid_o not seen, base %0h len %0d", b, l);
        end
        check("addr_q_drained", 512'(addr_q.size()), 512'(0));
        check("exp_q_drained", 512'(exp_q.size()), 512'(0));
        check("beat_count", 512'(hs_cnt), 512'(l));
        check("read_count", 512'(enp_cnt), 512'(l));
        check("wep_zero", 512'({a_wep, b_wep}), 512'(0));
        check("outstanding_max", 512'(max_out <= lat + 1), 512'(1));
        if (l != 0) begin
            check("first_read_cycle", 512'(first_enp), 512'(st_edge));
            check("first_valid_latency", 512'(first_valid - st_edge), 512'(lat + 1));
            check("done_after_last", 512'(done_cyc), 512'(last_hs + 1));
            if (m == 0) begin
                check("beats_back_to_back", 512'(last_hs - first_hs), 512'(l - 1));
                check("reads_back_to_back", 512'(last_enp - first_enp), 512'(l - 1));
            end
        end else begin
            check("len0_done_cycle", 512'(done_cyc), 512'(st_edge));
            check("len0_no_valid", 512'(first_valid), 512'(-1));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("done_hold", 512'(v_valid), 512'(1));
        @(negedge clk);
        check("idle_return", 512'(v_valid), 512'(0));
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; sel = 1'b0; rmode = 0; base = '0; len = '0;
        repeat (2) @(negedge clk);
        check("reset_a_outputs",
              512'({a_valid, a_enp, a_wep, a_addr, a_mvalid, a_mdata, a_mlast}), 512'(0));
        check("reset_b_outputs",
              512'({b_valid, b_enp, b_wep, b_addr, b_mvalid, b_mdata, b_mlast}), 512'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run(1'b0, 16'h0010, 16'd4, 0, 1);
        run(1'b0, 16'h0000, 16'd0, 0, 1);
        run(1'b0, 16'h0040, 16'd6, 1, 1);
        run(1'b0, 16'hFFFE, 16'd3, 0, 1);

        // Reset while the third of eight beats is on the stream.
        start_only(1'b0, 16'h0100, 16'd8, 0);
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (hs_cnt >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL rst_test_timeout: only %0d beats seen", hs_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        addr_q.delete();
        exp_q.delete();
        #1;
        check("midrun_reset_outputs",
              512'({a_valid, a_enp, a_wep, a_addr, a_mvalid, a_mdata, a_mlast}), 512'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(1'b0, 16'h0020, 16'd2, 0, 1);

        run(1'b1, 16'h0080, 16'd8, 0, 2);
        run(1'b1, 16'h0003, 16'd5, 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
- Reads the matrix product back out of global buffer P after the mm controller has finished writing it.
- Streams each P row to the host side over a valid/ready interface with full backpressure.
- Sits between global buffer P's read port and the host output DMA/stream.
- Issued by the top level after the controller's valid_o, using the same level-sensitive start/valid handshake.

Parameters:
- ADDR_W, 16, width of P buffer addresses and length.
- DATA_W, 256, width of one P row (8 lanes x 32 bits).
- RD_LAT, 1, P buffer read latency in cycles; supported values are 1 and 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  level start; sampled only in IDLE.
- valid_o  out  1  high in DONE.
- base_addr_i  in  ADDR_W  first P address to read; held stable while not IDLE.
- len_i  in  ADDR_W  number of rows to read; held stable while not IDLE.
- enp_o  out  1  P buffer enable (read).
- wep_o  out  1  P buffer write enable; constant 0.
- addrp_o  out  ADDR_W  P buffer address.
- datap_i  in  DATA_W  P buffer read data; valid RD_LAT cycles after enp_o.
- m_valid_o  out  1  output stream valid.
- m_ready_i  in  1  output stream ready.
- m_data_o  out  DATA_W  output row.
- m_last_o  out  1  high on the beat carrying row len_i-1.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and the FIFO cleared.
- Reset mid-operation: in-flight reads and buffered rows are discarded; no beat is emitted after reset.
- State machine (IDLE/BUSY/DONE):
  - IDLE -> BUSY on start_i=1 with len_i!=0.
  - IDLE -> DONE on start_i=1 with len_i==0; no reads are issued.
  - BUSY -> DONE in the cycle after the last beat handshakes (m_valid_o & m_ready_i & m_last_o).
  - DONE -> IDLE when start_i=0.
  - valid_o = (state==DONE).
- Read issue:
  - Counter rd_cnt counts 0..len_i-1.
  - enp_o=1 when state==BUSY, rd_cnt<len_i, and credit>0.
  - addrp_o = base_addr_i + rd_cnt when enp_o=1, else 0. Addition is modulo 2^ADDR_W (wraps).
  - rd_cnt increments on each issued read.
- Read pipeline: a RD_LAT-deep valid shift register tracks in-flight reads. datap_i is captured into the output FIFO on the cycle the delayed valid emerges.
- Output FIFO and credit:
  - Output FIFO is 2 entries (RD_LAT=1) or 3 entries (RD_LAT=2); depth = RD_LAT+1.
  - credit = depth - (fifo occupancy + in-flight reads). A read is issued only when credit>0, so the FIFO never overflows.
  - The credit calculation includes the current-cycle pop, so a sustained m_ready_i=1 gives 1 row/cycle throughput after an initial latency of RD_LAT+1 cycles (start sampled -> first m_valid_o).
  - Simultaneous push and pop in one cycle: occupancy is unchanged and data order is preserved.
- Stream rules:
  - m_valid_o = FIFO non-empty.
  - m_data_o and m_last_o are held stable while m_valid_o=1 and m_ready_i=0.
  - m_valid_o never drops without a handshake.
  - m_last_o is tagged at issue time (rd_cnt==len_i-1) and travels with the data.
- Beat counter: out_cnt counts handshakes. m_last_o must coincide with out_cnt==len_i-1; this is an assertion.
- wep_o is tied to 0. The block never writes P.
- start_i is ignored in BUSY. start_i held high in DONE keeps the block in DONE.

Test Plan:
- base=0x0010, len=4, m_ready_i=1, P[0x10..0x13]=R0..R3 -> addrp_o 0x10,0x11,0x12,0x13 on consecutive cycles; beats R0..R3 on 4 consecutive cycles; m_last_o only on R3; valid_o high the cycle after R3.
- len=0, start pulse -> no enp_o, no m_valid_o; valid_o=1 next cycle; IDLE after start_i=0.
- len=6, m_ready_i toggling 1,0,0,1,... -> rows emitted in order with no loss or duplication; enp_o stalls whenever credit=0; FIFO occupancy never exceeds 2.
- base=0xFFFE, len=3 -> addrp_o 0xFFFE, 0xFFFF, 0x0000.
- rst_i asserted during the 3rd of 8 beats -> all outputs 0 next edge; a fresh start with len=2 yields exactly 2 correct beats.
- RD_LAT=2, len=8, m_ready_i=1 -> first m_valid_o 3 cycles after start; 8 back-to-back beats.
